// File: rtl/irq_ctrl_prio_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_prio_pkg
// Shared definitions for the prioritised interrupt controller: register
// offsets within the 256-byte config window, the "no winner" vector value,
// the AXI OKAY response code and a register-select decoder used by both the
// read and the write paths.
// No ports (package).
// ---------------------------------------------------------------------------
package irq_ctrl_prio_pkg;

    localparam logic [7:0] ADDR_ISR       = 8'h00;
    localparam logic [7:0] ADDR_IPR       = 8'h04;
    localparam logic [7:0] ADDR_IER       = 8'h08;
    localparam logic [7:0] ADDR_IAR       = 8'h0C;
    localparam logic [7:0] ADDR_SIE       = 8'h10;
    localparam logic [7:0] ADDR_CIE       = 8'h14;
    localparam logic [7:0] ADDR_IVR       = 8'h18;
    localparam logic [7:0] ADDR_MER       = 8'h1C;
    localparam logic [7:0] ADDR_ITR       = 8'h20;
    localparam logic [7:0] ADDR_THR       = 8'h24;
    localparam logic [7:0] ADDR_PRIO_BASE = 8'h40;

    localparam logic [31:0] IVR_NONE  = 32'hFFFF_FFFF;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        REG_ISR,
        REG_IPR,
        REG_IER,
        REG_IAR,
        REG_SIE,
        REG_CIE,
        REG_IVR,
        REG_MER,
        REG_ITR,
        REG_THR,
        REG_PRIO,
        REG_NONE
    } reg_sel_e;

    // Maps a word offset onto a register. PRIO slots exist only for the
    // sources actually built, so anything past the last one decodes as NONE.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr, input int num_irq);
        reg_sel_e sel;
        sel = REG_NONE;
        case (addr)
            ADDR_ISR: sel = REG_ISR;
            ADDR_IPR: sel = REG_IPR;
            ADDR_IER: sel = REG_IER;
            ADDR_IAR: sel = REG_IAR;
            ADDR_SIE: sel = REG_SIE;
            ADDR_CIE: sel = REG_CIE;
            ADDR_IVR: sel = REG_IVR;
            ADDR_MER: sel = REG_MER;
            ADDR_ITR: sel = REG_ITR;
            ADDR_THR: sel = REG_THR;
            default: begin
                if ((addr[1:0] == 2'b00) && (addr >= ADDR_PRIO_BASE) &&
                    (int'(addr) < int'(ADDR_PRIO_BASE) + 4 * num_irq)) begin
                    sel = REG_PRIO;
                end
            end
        endcase
        return sel;
    endfunction

    // Source index of a PRIO slot; only meaningful when decode_addr says REG_PRIO.
    function automatic logic [5:0] prio_index(input logic [7:0] addr);
        return addr[7:2] - 6'h10;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_sync.sv
// ---------------------------------------------------------------------------
// irq_ctrl_prio_sync
// Multi-flop resynchroniser for one asynchronous interrupt source.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset, clears the chain to 0
//   d_i     asynchronous input
//   q_o     synchronised output, STAGES clocks behind d_i
// ---------------------------------------------------------------------------
module irq_ctrl_prio_sync
    import irq_ctrl_prio_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl_prio.sv
// ---------------------------------------------------------------------------
// irq_ctrl_prio
// Prioritised interrupt controller with an AXI4-Lite configuration slave.
// Each source is resynchronised, optionally edge-detected, latched as
// pending, masked by enable and priority-versus-threshold, and the highest
// priority eligible source (lowest index on a tie) is reported as the vector.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cfg_aw*/cfg_w*/cfg_b*    AXI4-Lite write channels (addr[7:0] decoded)
//   cfg_ar*/cfg_r*           AXI4-Lite read channels
//   irq_i[NUM_IRQ]           asynchronous active-high interrupt sources
//   intr_o                   registered interrupt request to the CPU
// ---------------------------------------------------------------------------
module irq_ctrl_prio
    import irq_ctrl_prio_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_awvalid_i,
    output logic               cfg_awready_o,
    input  logic [31:0]        cfg_awaddr_i,
    input  logic               cfg_wvalid_i,
    output logic               cfg_wready_o,
    input  logic [31:0]        cfg_wdata_i,
    input  logic [3:0]         cfg_wstrb_i,
    output logic               cfg_bvalid_o,
    input  logic               cfg_bready_i,
    output logic [1:0]         cfg_bresp_o,
    input  logic               cfg_arvalid_i,
    output logic               cfg_arready_o,
    input  logic [31:0]        cfg_araddr_i,
    output logic               cfg_rvalid_o,
    input  logic               cfg_rready_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [1:0]         cfg_rresp_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               intr_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // Bus channel state
    logic        aw_held_q, w_held_q, bvalid_q, rvalid_q, ready_en_q;
    logic [7:0]  aw_addr_q;
    logic [31:0] w_data_q, rdata_q;
    logic        aw_hs, w_hs, ar_hs, wr_fire;

    // Controller state
    logic [NUM_IRQ-1:0] pending_q, ier_q, itr_q, src_p_q;
    logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
    logic [PRIO_W-1:0]  thr_q;
    logic               mer_q, intr_q;

    logic [NUM_IRQ-1:0] src_s, hw_set, sw_set, ack, eligible, wr_mask;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [PRIO_W-1:0]  win_prio;
    reg_sel_e           wr_sel, rd_sel;
    logic [5:0]         wr_prio_idx, rd_prio_idx;
    logic [31:0]        rd_data;

    logic unused_ok;
    assign unused_ok = ^{cfg_awaddr_i[31:8], cfg_araddr_i[31:8], cfg_wstrb_i, w_data_q};

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        irq_ctrl_prio_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (irq_i[gi]),
            .q_o   (src_s[gi])
        );
    end

    // ready_en_q keeps every ready low while reset is held, so the slave
    // presents all-zero outputs during reset.
    assign cfg_awready_o = ready_en_q & ~bvalid_q & ~cfg_arvalid_i & ~aw_held_q;
    assign cfg_wready_o  = ready_en_q & ~bvalid_q & ~cfg_arvalid_i & ~w_held_q;
    assign cfg_arready_o = ready_en_q & ~rvalid_q;
    assign aw_hs   = cfg_awvalid_i & cfg_awready_o;
    assign w_hs    = cfg_wvalid_i & cfg_wready_o;
    assign ar_hs   = cfg_arvalid_i & cfg_arready_o;
    assign wr_fire = aw_held_q & w_held_q;

    assign cfg_bvalid_o = bvalid_q;
    assign cfg_bresp_o  = RESP_OKAY;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign cfg_rresp_o  = RESP_OKAY;
    assign intr_o       = intr_q;

    // Write-side decode; ISR and IAR writes become one-cycle set/clear masks
    // that fold into the pending update.
    always_comb begin
        wr_sel      = decode_addr(aw_addr_q, NUM_IRQ);
        wr_prio_idx = prio_index(aw_addr_q);
        wr_mask     = w_data_q[NUM_IRQ-1:0];
        sw_set      = (wr_fire && wr_sel == REG_ISR) ? wr_mask : '0;
        ack         = (wr_fire && wr_sel == REG_IAR) ? wr_mask : '0;
    end

    // In edge mode only a 0->1 step of the synchronised input sets pending;
    // in level mode the input sets pending every cycle it is high.
    assign hw_set = (itr_q & src_s & ~src_p_q) | (~itr_q & src_s);

    // Eligibility and winner search. Strict '>' means an earlier (lower)
    // index keeps the win on a priority tie; priority 0 can never exceed
    // the threshold and so never becomes eligible.
    always_comb begin
        eligible  = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = pending_q[i] & ier_q[i] & (prio_q[i] > thr_q);
            if (eligible[i] && (!win_valid || prio_q[i] > win_prio)) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_prio  = prio_q[i];
            end
        end
    end

    // Read mux, captured into rdata_q at AR accept so the returned word is
    // frozen while rvalid waits for rready.
    always_comb begin
        rd_sel      = decode_addr(cfg_araddr_i[7:0], NUM_IRQ);
        rd_prio_idx = prio_index(cfg_araddr_i[7:0]);
        rd_data     = '0;
        case (rd_sel)
            REG_ISR: rd_data = 32'(pending_q);
            REG_IPR: rd_data = 32'(pending_q & ier_q);
            REG_IER: rd_data = 32'(ier_q);
            REG_IVR: rd_data = win_valid ? 32'(win_idx) : IVR_NONE;
            REG_MER: rd_data = 32'(mer_q);
            REG_ITR: rd_data = 32'(itr_q);
            REG_THR: rd_data = 32'(thr_q);
            REG_PRIO: begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (rd_prio_idx == 6'(i)) begin
                        rd_data = 32'(prio_q[i]);
                    end
                end
            end
            default: rd_data = '0;
        endcase
    end

    // AXI4-Lite channel handling. AW and W are held independently until both
    // are present, then the write fires; a pending AR blocks new AW/W so the
    // read is always served first.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= cfg_awaddr_i[7:0];
            end else if (wr_fire) begin
                aw_held_q <= 1'b0;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= cfg_wdata_i;
            end else if (wr_fire) begin
                w_held_q <= 1'b0;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (cfg_bready_i) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end else if (cfg_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Controller registers. A set in the same cycle as an ack wins, so an
    // event arriving while software acknowledges is never lost.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
            ier_q     <= '0;
            itr_q     <= '0;
            src_p_q   <= '0;
            thr_q     <= '0;
            mer_q     <= 1'b0;
            intr_q    <= 1'b0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~ack) | hw_set | sw_set;
            src_p_q   <= src_s;
            intr_q    <= mer_q & (|eligible);
            if (wr_fire) begin
                case (wr_sel)
                    REG_IER: ier_q <= wr_mask;
                    REG_SIE: ier_q <= ier_q | wr_mask;
                    REG_CIE: ier_q <= ier_q & ~wr_mask;
                    REG_MER: mer_q <= w_data_q[0];
                    REG_ITR: itr_q <= wr_mask;
                    REG_THR: thr_q <= w_data_q[PRIO_W-1:0];
                    REG_PRIO: begin
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            if (wr_prio_idx == 6'(i)) begin
                                prio_q[i] <= w_data_q[PRIO_W-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl_prio.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl_prio
// Directed bench for irq_ctrl_prio (NUM_IRQ=8, PRIO_W=3, SYNC_STAGES=2).
// Bus drivers push the expected read word / write response into queues;
// a monitor pops and compares whenever a response handshake occurs.
// ---------------------------------------------------------------------------
module tb_irq_ctrl_prio;

    localparam int NUM_IRQ = 8;
    localparam int PRIO_W  = 3;
    localparam int SYNC    = 2;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               cfg_awvalid_i, cfg_awready_o;
    logic [31:0]        cfg_awaddr_i;
    logic               cfg_wvalid_i, cfg_wready_o;
    logic [31:0]        cfg_wdata_i;
    logic [3:0]         cfg_wstrb_i;
    logic               cfg_bvalid_o, cfg_bready_i;
    logic [1:0]         cfg_bresp_o;
    logic               cfg_arvalid_i, cfg_arready_o;
    logic [31:0]        cfg_araddr_i;
    logic               cfg_rvalid_o, cfg_rready_i;
    logic [31:0]        cfg_rdata_o;
    logic [1:0]         cfg_rresp_o;
    logic [NUM_IRQ-1:0] irq_i;
    logic               intr_o;

    irq_ctrl_prio #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_awvalid_i(cfg_awvalid_i), .cfg_awready_o(cfg_awready_o), .cfg_awaddr_i(cfg_awaddr_i),
        .cfg_wvalid_i(cfg_wvalid_i), .cfg_wready_o(cfg_wready_o), .cfg_wdata_i(cfg_wdata_i),
        .cfg_wstrb_i(cfg_wstrb_i), .cfg_bvalid_o(cfg_bvalid_o), .cfg_bready_i(cfg_bready_i),
        .cfg_bresp_o(cfg_bresp_o), .cfg_arvalid_i(cfg_arvalid_i), .cfg_arready_o(cfg_arready_o),
        .cfg_araddr_i(cfg_araddr_i), .cfg_rvalid_o(cfg_rvalid_o), .cfg_rready_i(cfg_rready_i),
        .cfg_rdata_o(cfg_rdata_o), .cfg_rresp_o(cfg_rresp_o), .irq_i(irq_i), .intr_o(intr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int vectors     = 0;
    int miscompares = 0;
    int r_done      = 0;
    int b_done      = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Response monitor: samples 2 time units after the falling edge, i.e.
    // the values the next rising edge will see.
    initial begin
        rexp_t      re;
        logic [1:0] be;
        forever begin
            @(negedge clk_i);
            #2;
            if (cfg_rvalid_o && cfg_rready_i) begin
                r_done++;
                if (rq.size() == 0) begin
                    report_timeout("unexpected rvalid");
                end else begin
                    re = rq.pop_front();
                    check_output($sformatf("rdata@%h", re.addr), cfg_rdata_o, re.data);
                    check_output("rresp", {30'd0, cfg_rresp_o}, 32'd0);
                end
            end
            if (cfg_bvalid_o && cfg_bready_i) begin
                b_done++;
                if (bq.size() == 0) begin
                    report_timeout("unexpected bvalid");
                end else begin
                    be = bq.pop_front();
                    check_output("bresp", {30'd0, cfg_bresp_o}, {30'd0, be});
                end
            end
        end
    end

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp);
        int   start;
        logic hs;
        hs = 1'b0;
        rq.push_back('{exp, addr});
        start = r_done;
        @(negedge clk_i);
        cfg_arvalid_i = 1'b1;
        cfg_araddr_i  = {24'd0, addr};
        for (int n = 0; n < 50; n++) begin
            #1 hs = cfg_arready_o;
            @(negedge clk_i);
            if (hs) break;
        end
        cfg_arvalid_i = 1'b0;
        if (!hs) report_timeout("arready");
        for (int n = 0; n < 50 && r_done == start; n++) @(negedge clk_i);
        if (r_done == start) report_timeout("rvalid");
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
        int   start;
        logic aw_hs, w_hs;
        bq.push_back(2'b00);
        start = b_done;
        @(negedge clk_i);
        cfg_awvalid_i = 1'b1;
        cfg_awaddr_i  = {24'd0, addr};
        cfg_wvalid_i  = 1'b1;
        cfg_wdata_i   = data;
        for (int n = 0; n < 50 && (cfg_awvalid_i || cfg_wvalid_i); n++) begin
            #1;
            aw_hs = cfg_awvalid_i && cfg_awready_o;
            w_hs  = cfg_wvalid_i && cfg_wready_o;
            @(negedge clk_i);
            if (aw_hs) cfg_awvalid_i = 1'b0;
            if (w_hs)  cfg_wvalid_i  = 1'b0;
        end
        if (cfg_awvalid_i || cfg_wvalid_i) report_timeout("aw/w ready");
        cfg_awvalid_i = 1'b0;
        cfg_wvalid_i  = 1'b0;
        for (int n = 0; n < 50 && b_done == start; n++) @(negedge clk_i);
        if (b_done == start) report_timeout("bvalid");
    endtask

    task automatic check_intr(input string name, input logic exp);
        @(negedge clk_i);
        #2 check_output(name, {31'd0, intr_o}, {31'd0, exp});
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   first, r0, b0;
        logic brk;
        rst_ni = 1'b0;
        cfg_awvalid_i = 1'b0; cfg_awaddr_i = '0;
        cfg_wvalid_i = 1'b0;  cfg_wdata_i = '0; cfg_wstrb_i = 4'hF;
        cfg_arvalid_i = 1'b0; cfg_araddr_i = '0;
        cfg_bready_i = 1'b1;  cfg_rready_i = 1'b1;
        irq_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // T1: reset asserted for 3 cycles while a MER write is in flight
        $display("[TB] T1 reset");
        @(negedge clk_i);
        cfg_awvalid_i = 1'b1; cfg_awaddr_i = 32'h1C;
        cfg_wvalid_i  = 1'b1; cfg_wdata_i  = 32'h1;
        #1 check_output("T1 awready before reset", {31'd0, cfg_awready_o}, 32'd1);
        @(negedge clk_i);
        cfg_awvalid_i = 1'b0; cfg_wvalid_i = 1'b0;
        rst_ni = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            #2 check_output("T1 outputs in reset",
                {26'd0, cfg_awready_o, cfg_wready_o, cfg_arready_o, cfg_bvalid_o, cfg_rvalid_o, intr_o}, 32'd0);
        end
        check_output("T1 rdata in reset", cfg_rdata_o, 32'd0);
        rst_ni = 1'b1;
        axi_read(8'h08, 32'h0);
        axi_read(8'h1C, 32'h0);
        axi_read(8'h40, 32'h0);
        axi_read(8'h18, 32'hFFFF_FFFF);

        // T2: level source 3
        $display("[TB] T2 level");
        axi_write(8'h4C, 32'd2);
        axi_write(8'h24, 32'd0);
        axi_write(8'h08, 32'h08);
        axi_write(8'h1C, 32'h1);
        @(negedge clk_i);
        irq_i[3] = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            #2 if (intr_o && first == 0) first = k;
        end
        check_output("T2 intr latency edges", first, SYNC + 2);
        axi_read(8'h18, 32'd3);
        axi_read(8'h04, 32'h08);
        axi_write(8'h0C, 32'h08);
        repeat (2) @(negedge clk_i);
        axi_read(8'h00, 32'h08);
        check_intr("T2 intr after ack while high", 1'b1);
        irq_i[3] = 1'b0;
        repeat (4) @(negedge clk_i);
        axi_write(8'h0C, 32'h08);
        check_intr("T2 intr after drop+ack", 1'b0);
        axi_read(8'h00, 32'h0);

        // T3: edge source 1
        $display("[TB] T3 edge");
        axi_write(8'h20, 32'h02);
        @(negedge clk_i); irq_i[1] = 1'b1;
        @(negedge clk_i); irq_i[1] = 1'b0;
        repeat (5) @(negedge clk_i);
        axi_read(8'h00, 32'h02);
        axi_write(8'h0C, 32'h02);
        axi_read(8'h00, 32'h0);
        @(negedge clk_i); irq_i[1] = 1'b1;
        repeat (5) @(negedge clk_i);
        axi_read(8'h00, 32'h02);
        axi_write(8'h0C, 32'h02);
        repeat (4) @(negedge clk_i);
        axi_read(8'h00, 32'h0);
        irq_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        axi_read(8'h00, 32'h0);

        // T4: priority, tie-break and threshold
        $display("[TB] T4 priority");
        axi_write(8'h40, 32'd1);
        axi_write(8'h54, 32'd4);
        axi_write(8'h58, 32'd4);
        axi_write(8'h08, 32'h61);
        axi_write(8'h00, 32'h61);
        axi_read(8'h04, 32'h61);
        axi_read(8'h18, 32'd5);
        check_intr("T4 intr eligible", 1'b1);
        axi_write(8'h24, 32'd4);
        repeat (2) @(negedge clk_i);
        check_intr("T4 intr at THR=4", 1'b0);
        axi_read(8'h18, 32'hFFFF_FFFF);
        axi_write(8'h24, 32'd3);
        axi_write(8'h54, 32'd3);
        axi_read(8'h54, 32'd3);
        axi_read(8'h18, 32'd6);
        axi_write(8'h0C, 32'h61);
        axi_read(8'h00, 32'h0);
        axi_write(8'h24, 32'd0);
        axi_write(8'h08, 32'hFFFF_FF80);
        axi_read(8'h08, 32'h80);
        axi_write(8'h00, 32'h80);
        axi_read(8'h18, 32'hFFFF_FFFF);
        axi_write(8'h0C, 32'h80);
        axi_write(8'h14, 32'h80);
        axi_write(8'h10, 32'h03);
        axi_read(8'h08, 32'h03);
        axi_write(8'h14, 32'h03);
        axi_write(8'h60, 32'h7);
        axi_read(8'h60, 32'h0);
        axi_read(8'h3C, 32'h0);

        // T5: W leads AW by 3 cycles, AR concurrent with AW
        $display("[TB] T5 bus ordering");
        r0 = r_done; b0 = b_done;
        cfg_rready_i = 1'b0; cfg_bready_i = 1'b0;
        rq.push_back('{32'h0, 8'h08});
        bq.push_back(2'b00);
        @(negedge clk_i);
        cfg_wvalid_i = 1'b1; cfg_wdata_i = 32'h55;
        #1 check_output("T5 wready alone", {31'd0, cfg_wready_o}, 32'd1);
        @(negedge clk_i);
        cfg_wvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        cfg_awvalid_i = 1'b1; cfg_awaddr_i = 32'h08;
        cfg_arvalid_i = 1'b1; cfg_araddr_i = 32'h08;
        #1 check_output("T5 arready/awready", {30'd0, cfg_arready_o, cfg_awready_o}, 32'b10);
        @(negedge clk_i);
        cfg_arvalid_i = 1'b0;
        #1 check_output("T5 awready/wready after AR", {30'd0, cfg_awready_o, cfg_wready_o}, 32'b10);
        @(negedge clk_i);
        cfg_awvalid_i = 1'b0;
        brk = 1'b0;
        for (int n = 0; n < 20 && !brk; n++) begin
            #2 brk = cfg_bvalid_o;
            if (!brk) @(negedge clk_i);
        end
        if (!brk) report_timeout("T5 bvalid");
        repeat (5) begin
            @(negedge clk_i);
            #2 check_output("T5 rvalid/bvalid held", {30'd0, cfg_rvalid_o, cfg_bvalid_o}, 32'b11);
        end
        @(negedge clk_i); cfg_rready_i = 1'b1;
        @(negedge clk_i); cfg_rready_i = 1'b0; cfg_bready_i = 1'b1;
        @(negedge clk_i); cfg_bready_i = 1'b0;
        #2 check_output("T5 both released", {30'd0, cfg_rvalid_o, cfg_bvalid_o}, 32'b00);
        cfg_rready_i = 1'b1; cfg_bready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_output("T5 rvalid count", r_done - r0, 32'd1);
        check_output("T5 bvalid count", b_done - b0, 32'd1);
        axi_read(8'h08, 32'h55);

        // T6: hardware edge on source 0 lands with the IAR write
        $display("[TB] T6 set/ack race");
        axi_write(8'h20, 32'h03);
        axi_write(8'h00, 32'h01);
        axi_read(8'h00, 32'h01);
        b0 = b_done;
        bq.push_back(2'b00);
        @(negedge clk_i);
        irq_i[0] = 1'b1;
        @(negedge clk_i);
        cfg_awvalid_i = 1'b1; cfg_awaddr_i = 32'h0C;
        cfg_wvalid_i  = 1'b1; cfg_wdata_i  = 32'h01;
        #1 check_output("T6 aw/w ready", {30'd0, cfg_awready_o, cfg_wready_o}, 32'b11);
        @(negedge clk_i);
        cfg_awvalid_i = 1'b0; cfg_wvalid_i = 1'b0;
        for (int n = 0; n < 20 && b_done == b0; n++) @(negedge clk_i);
        if (b_done == b0) report_timeout("T6 bvalid");
        axi_read(8'h00, 32'h01);
        axi_write(8'h0C, 32'h01);
        repeat (3) @(negedge clk_i);
        axi_read(8'h00, 32'h0);
        irq_i[0] = 1'b0;

        repeat (4) @(negedge clk_i);
        check_output("scoreboard drained", rq.size() + bq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
